// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FP issue/writeback scheduler: funct7 opcodes,
// the execution-class enum, the reservation ring depth and the class decoder.
package fpu_sched_pkg;

  localparam logic [6:0] FADD  = 7'h00;
  localparam logic [6:0] FSUB  = 7'h04;
  localparam logic [6:0] FMUL  = 7'h08;
  localparam logic [6:0] FDIV  = 7'h0C;
  localparam logic [6:0] FSQRT = 7'h2C;
  localparam logic [6:0] FSGNJ = 7'h10;
  localparam logic [6:0] FCMP  = 7'h50;

  localparam int RING_DEPTH = 16;

  typedef enum logic [1:0] {
    MISC = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DIV  = 2'd3
  } fp_cls_e;

  // Any funct7 not owned by a pipelined/iterative unit goes to the
  // combinational MISC unit.
  function automatic fp_cls_e classify(input logic [6:0] funct7);
    case (funct7)
      FADD, FSUB:   classify = ADD;
      FMUL:         classify = MUL;
      FDIV, FSQRT:  classify = DIV;
      FSGNJ, FCMP:  classify = MISC;
      default:      classify = MISC;
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_resv_ring.sv
// Writeback reservation ring. Entry 0 is the slot whose unit result is
// sampled at the end of the current cycle; the ring shifts toward entry 0
// every cycle. A new op of latency lat lands in entry lat after the shift,
// so the collision query looks at entry lat+1 before the shift.
module fpu_wb_resv_ring
  import fpu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       set,
  input  logic [3:0] lat,
  input  logic [4:0] set_tag,
  input  fp_cls_e    set_cls,
  output logic       collide,
  output logic       head_vld,
  output logic [4:0] head_tag,
  output fp_cls_e    head_cls
);

  logic [RING_DEPTH-1:0] vld;
  logic [4:0]            tag [RING_DEPTH];
  fp_cls_e               cls [RING_DEPTH];
  logic [4:0]            query_slot;

  // Slot lat+1 == 16 lies beyond the ring and can never hold a reservation.
  always_comb begin
    query_slot = {1'b0, lat} + 5'd1;
    collide    = !query_slot[4] && vld[query_slot[3:0]];
    head_vld   = vld[0];
    head_tag   = tag[0];
    head_cls   = cls[0];
  end

  // Shift every cycle, drop everything on clear, insert new reservation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int i = 0; i < RING_DEPTH; i++) begin
        tag[i] <= '0;
        cls[i] <= MISC;
      end
    end else if (clear) begin
      vld <= '0;
    end else begin
      vld <= {1'b0, vld[RING_DEPTH-1:1]};
      for (int i = 0; i < RING_DEPTH - 1; i++) begin
        tag[i] <= tag[i+1];
        cls[i] <= cls[i+1];
      end
      if (set) begin
        vld[lat] <= 1'b1;
        tag[lat] <= set_tag;
        cls[lat] <= set_cls;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// FP issue and writeback scheduler: accepts one op per cycle, strobes the
// matching unit, reserves the shared writeback slot and retires results.
// Optional build macro FPU_ISSUE_SCHED_PERF_EN adds stall/retire counters.
module fpu_issue_sched
  import fpu_sched_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_x1,
  input  logic [31:0] req_x2,
  output logic [6:0]  op_funct7,
  output logic [2:0]  op_funct3,
  output logic [31:0] op_x1,
  output logic [31:0] op_x2,
  output logic        misc_en,
  output logic        add_en,
  output logic        mul_en,
  output logic        div_en,
  output logic        unit_flush,
  input  logic [31:0] misc_y,
  input  logic [31:0] add_y,
  input  logic [31:0] mul_y,
  input  logic [31:0] div_y,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_y
`ifdef FPU_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] retire_cnt
`endif
);

  function automatic logic [3:0] lat_of(input fp_cls_e c);
    case (c)
      ADD:     lat_of = 4'(ADD_LAT);
      MUL:     lat_of = 4'(MUL_LAT);
      DIV:     lat_of = 4'(DIV_LAT);
      default: lat_of = 4'd0;
    endcase
  endfunction

  fp_cls_e     cls_p0;
  logic [3:0]  lat_p0;
  logic        collide;
  logic        div_block;
  logic        accept;
  logic [4:0]  div_cnt;
  logic        head_vld;
  logic [4:0]  head_tag;
  fp_cls_e     head_cls;
  logic [31:0] wb_sel;

  // Issue gating: a DIV may go in the cycle the busy counter reads 1.
  always_comb begin
    cls_p0    = classify(req_funct7);
    lat_p0    = lat_of(cls_p0);
    div_block = (cls_p0 == DIV) && (div_cnt > 5'd1);
    req_ready = rstn && !flush && !collide && !div_block;
    accept    = req_valid && req_ready;
  end

  fpu_wb_resv_ring u_ring (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (flush),
    .set      (accept),
    .lat      (lat_p0),
    .set_tag  (req_rd),
    .set_cls  (cls_p0),
    .collide  (collide),
    .head_vld (head_vld),
    .head_tag (head_tag),
    .head_cls (head_cls)
  );

  // Div/sqrt occupancy countdown, cleared by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (flush) begin
      div_cnt <= '0;
    end else if (accept && cls_p0 == DIV) begin
      div_cnt <= 5'(DIV_LAT + 1);
    end else if (div_cnt != 5'd0) begin
      div_cnt <= div_cnt - 5'd1;
    end
  end

  // ---- stage p0 -> p1: op cycle, operands and class strobes ----
  // Capture accepted op fields and raise the one-cycle class strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_funct7  <= '0;
      op_funct3  <= '0;
      op_x1      <= '0;
      op_x2      <= '0;
      misc_en    <= 1'b0;
      add_en     <= 1'b0;
      mul_en     <= 1'b0;
      div_en     <= 1'b0;
      unit_flush <= 1'b0;
    end else begin
      misc_en    <= accept && (cls_p0 == MISC);
      add_en     <= accept && (cls_p0 == ADD);
      mul_en     <= accept && (cls_p0 == MUL);
      div_en     <= accept && (cls_p0 == DIV);
      unit_flush <= flush;
      if (accept) begin
        op_funct7 <= req_funct7;
        op_funct3 <= req_funct3;
        op_x1     <= req_x1;
        op_x2     <= req_x2;
      end
    end
  end

  // Pick the result of the unit that owns the head slot.
  always_comb begin
    case (head_cls)
      ADD:     wb_sel = add_y;
      MUL:     wb_sel = mul_y;
      DIV:     wb_sel = div_y;
      default: wb_sel = misc_y;
    endcase
  end

  // ---- stage result -> wb: registered writeback ----
  // Retire the head slot; a flush in the same cycle suppresses it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_y     <= '0;
    end else begin
      wb_valid <= head_vld && !flush;
      if (head_vld) begin
        wb_rd <= head_tag;
        wb_y  <= wb_sel;
      end
    end
  end

`ifdef FPU_ISSUE_SCHED_PERF_EN
  // Free-running stall and retire counters, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (req_valid && !req_ready && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (wb_valid) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
